// File: rtl/parity_engine_n.sv
// XOR parity engine: fetches a work descriptor, reads NUM_STRIPES source lines per
// 128-byte line, XORs them into an accumulator and writes the parity line back.
module parity_engine_n #(
    parameter int NUM_STRIPES = 2,
    parameter int ADDR_W      = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] job_address,
    output logic              cmd_valid,
    output logic [12:0]       cmd_command,
    output logic [7:0]        cmd_tag,
    output logic [ADDR_W-1:0] cmd_address,
    output logic [11:0]       cmd_size,
    output logic              cmd_command_parity,
    output logic              cmd_tag_parity,
    output logic              cmd_address_parity,
    input  logic              cmd_credit,
    input  logic              bw_valid,
    input  logic [7:0]        bw_tag,
    input  logic              bw_half,
    input  logic [511:0]      bw_data,
    input  logic              br_valid,
    input  logic [7:0]        br_tag,
    input  logic              br_half,
    output logic [511:0]      br_data,
    input  logic              rsp_valid,
    input  logic [7:0]        rsp_tag,
    input  logic [7:0]        rsp_code,
    output logic              done,
    output logic              error
);

    localparam int          NUM_W      = NUM_STRIPES + 2;
    localparam logic [12:0] CMD_READ   = 13'h0A00;
    localparam logic [12:0] CMD_WRITE  = 13'h0D00;
    localparam logic [7:0]  TAG_DESC   = 8'h00;
    localparam logic [7:0]  TAG_PARITY = 8'h80;
    localparam logic [63:0] LINE_BYTES = 64'd128;

    typedef enum logic [3:0] {
        IDLE, FETCH_DESC, WAIT_DESC, READ_STRIPES, WAIT_STRIPES,
        WRITE_PARITY, WAIT_WRITE, DONE, ERROR
    } state_t;

    state_t       state_q;
    logic [63:0]  desc_q [NUM_W];
    logic [2:0]   stripe_idx_q;
    logic [3:0]   rsp_cnt_q;
    logic [63:0]  offset_q;
    logic [511:0] acc_h0_q, acc_h1_q;
    logic [511:0] br_data_p1;
    logic         done_q, error_q;

    function automatic logic [63:0] bswap64(input logic [63:0] w);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = w[56-8*i +: 8];
        return r;
    endfunction

    logic         in_stripe_phase, beat_stripe, rsp_stripe, rsp_is_err;
    logic         desc_rsp, desc_beat0, parity_rsp, first_issue;
    logic [63:0]  size_now, size_trunc, offset_next;
    logic [63:0]  stripe_ptr;
    logic [3:0]   rsp_cnt_d;
    logic [511:0] acc_h0_d, acc_h1_d;

    assign in_stripe_phase = (state_q == READ_STRIPES) || (state_q == WAIT_STRIPES);
    assign beat_stripe = enable && bw_valid && in_stripe_phase &&
                         (bw_tag >= 8'd1) && (bw_tag <= 8'(NUM_STRIPES));
    assign rsp_stripe  = enable && rsp_valid && in_stripe_phase &&
                         (rsp_tag >= 8'd1) && (rsp_tag <= 8'(NUM_STRIPES));
    assign rsp_is_err  = (rsp_code != 8'd0);
    assign desc_rsp    = enable && rsp_valid && (rsp_tag == TAG_DESC) && (state_q == WAIT_DESC);
    assign desc_beat0  = enable && bw_valid && (bw_tag == TAG_DESC) && !bw_half &&
                         (state_q == WAIT_DESC);
    assign parity_rsp  = enable && rsp_valid && (rsp_tag == TAG_PARITY) && (state_q == WAIT_WRITE);

    // Same-cycle descriptor beat and response: take the size straight from the beat.
    assign size_now    = desc_beat0 ? bswap64(bw_data[511:448]) : desc_q[0];
    assign size_trunc  = {desc_q[0][63:7], 7'd0};
    assign offset_next = offset_q + LINE_BYTES;

    assign cmd_valid   = enable && cmd_credit &&
                         ((state_q == FETCH_DESC) || (state_q == READ_STRIPES) ||
                          (state_q == WRITE_PARITY));
    assign first_issue = cmd_valid && (state_q == READ_STRIPES) && (stripe_idx_q == 3'd1);

    always_comb begin
        stripe_ptr = '0;
        for (int w = 1; w <= NUM_STRIPES; w++)
            if (w == int'(stripe_idx_q)) stripe_ptr = desc_q[w];
    end

    always_comb begin
        cmd_command = '0;
        cmd_tag     = '0;
        cmd_address = '0;
        unique case (state_q)
            FETCH_DESC: begin
                cmd_command = CMD_READ;
                cmd_tag     = TAG_DESC;
                cmd_address = job_address;
            end
            READ_STRIPES: begin
                cmd_command = CMD_READ;
                cmd_tag     = {5'd0, stripe_idx_q};
                cmd_address = stripe_ptr[ADDR_W-1:0] + offset_q[ADDR_W-1:0];
            end
            WRITE_PARITY: begin
                cmd_command = CMD_WRITE;
                cmd_tag     = TAG_PARITY;
                cmd_address = desc_q[NUM_STRIPES+1][ADDR_W-1:0] + offset_q[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

    assign cmd_size           = 12'd128;
    assign cmd_command_parity = ~^cmd_command;
    assign cmd_tag_parity     = ~^cmd_tag;
    assign cmd_address_parity = ~^cmd_address;

    // The beat is folded in before the completion count is compared.
    assign acc_h0_d  = (first_issue ? '0 : acc_h0_q) ^ ((beat_stripe && !bw_half) ? bw_data : '0);
    assign acc_h1_d  = (first_issue ? '0 : acc_h1_q) ^ ((beat_stripe &&  bw_half) ? bw_data : '0);
    assign rsp_cnt_d = (first_issue ? 4'd0 : rsp_cnt_q) +
                       ((rsp_stripe && !rsp_is_err) ? 4'd1 : 4'd0);

    always_ff @(posedge clock) begin
        if (enable && bw_valid && (bw_tag == TAG_DESC) && (state_q == WAIT_DESC)) begin
            for (int w = 0; w < NUM_W; w++)
                if (bw_half == (w >= 8))
                    desc_q[w] <= bswap64(bw_data[511 - 64*(w % 8) -: 64]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            stripe_idx_q <= 3'd1;
            rsp_cnt_q    <= '0;
            offset_q     <= '0;
            acc_h0_q     <= '0;
            acc_h1_q     <= '0;
            br_data_p1   <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else if (enable) begin
            acc_h0_q  <= acc_h0_d;
            acc_h1_q  <= acc_h1_d;
            rsp_cnt_q <= rsp_cnt_d;
            if (br_valid && (br_tag == TAG_PARITY))
                br_data_p1 <= br_half ? acc_h1_q : acc_h0_q;
            unique case (state_q)
                IDLE:       state_q <= FETCH_DESC;
                FETCH_DESC: if (cmd_valid) state_q <= WAIT_DESC;
                WAIT_DESC: begin
                    if (desc_rsp) begin
                        if (rsp_is_err) begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                        end else if (size_now[63:7] == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= READ_STRIPES;
                            offset_q     <= '0;
                            stripe_idx_q <= 3'd1;
                        end
                    end
                end
                READ_STRIPES: begin
                    if (rsp_stripe && rsp_is_err) begin
                        state_q <= ERROR;
                        error_q <= 1'b1;
                    end else if (cmd_valid) begin
                        if (stripe_idx_q == 3'(NUM_STRIPES)) state_q <= WAIT_STRIPES;
                        else stripe_idx_q <= stripe_idx_q + 3'd1;
                    end
                end
                WAIT_STRIPES: begin
                    if (rsp_stripe && rsp_is_err) begin
                        state_q <= ERROR;
                        error_q <= 1'b1;
                    end else if (rsp_cnt_d == 4'(NUM_STRIPES)) begin
                        state_q <= WRITE_PARITY;
                    end
                end
                WRITE_PARITY: if (cmd_valid) state_q <= WAIT_WRITE;
                WAIT_WRITE: begin
                    if (parity_rsp) begin
                        if (rsp_is_err) begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                        end else begin
                            offset_q <= offset_next;
                            if (offset_next == size_trunc) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q      <= READ_STRIPES;
                                stripe_idx_q <= 3'd1;
                            end
                        end
                    end
                end
                DONE:    done_q  <= 1'b1;
                ERROR:   error_q <= 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign br_data = br_data_p1;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: doc/parity_engine_n.md
PARITY_ENGINE_N -- requirements
Module: parity_engine_n

Interface
REQ-001 Parameter NUM_STRIPES, default 2: number of source stripes XORed per line; legal range 2..7.
REQ-002 Parameter ADDR_W, default 64: width of effective addresses.
REQ-003 clock  in  1  sole clock; all state is updated on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  job running; when low, all state holds and no new command issues.
REQ-006 job_address  in  ADDR_W  address of the 128-byte work descriptor.
REQ-007 cmd_valid / cmd_command[0:12] / cmd_tag[0:7] / cmd_address[0:ADDR_W-1] / cmd_size[0:11]  out  command issue.
REQ-008 cmd_command_parity / cmd_tag_parity / cmd_address_parity  out  1 each  odd parity (XNOR-reduce) of the matching field.
REQ-009 cmd_credit  in  1  a command may issue only in a cycle where this is high.
REQ-010 bw_valid / bw_tag[0:7] / bw_half / bw_data[0:511]  in  buffer-write beat: half 0 = bytes 0-63, half 1 = bytes 64-127.
REQ-011 br_valid / br_tag[0:7] / br_half  in, br_data[0:511]  out  buffer-read request; data returned one cycle later.
REQ-012 rsp_valid / rsp_tag[0:7] / rsp_code[0:7]  in  command completion; code 0 = DONE.
REQ-013 done, error  out  1 each  job complete / job aborted; both sticky until reset.

Function
REQ-014 Descriptor words are little-endian 64-bit values and are byte-swapped on capture.
REQ-015 Descriptor layout: word0 = size in bytes, words 1..NUM_STRIPES = stripe pointers, word NUM_STRIPES+1 = parity pointer.
REQ-016 Command encodings: READ_CL_NA = 0x0A00, WRITE_NA = 0x0D00; cmd_size is always 128.
REQ-017 Tags: 0x00 = descriptor, 0x01..NUM_STRIPES = stripe k, 0x80 = parity write.
REQ-018 States: IDLE, FETCH_DESC, WAIT_DESC, READ_STRIPES, WAIT_STRIPES, WRITE_PARITY, WAIT_WRITE, DONE, ERROR.
REQ-019 IDLE -> FETCH_DESC in the first enabled cycle.
REQ-020 FETCH_DESC issues READ_CL_NA to job_address with tag 0, then moves to WAIT_DESC.
REQ-021 WAIT_DESC captures descriptor half 0 on a bw beat with tag 0.
REQ-022 WAIT_DESC leaves on the tag-0 response: -> READ_STRIPES, or -> DONE if size < 128.
REQ-023 size is truncated to a multiple of 128; the line offset starts at 0.
REQ-024 READ_STRIPES issues NUM_STRIPES reads, one per credited cycle, stripe k at pointer_k + offset with tag k.
REQ-025 The 1024-bit accumulator clears on the first stripe issue of each line.
REQ-026 Each bw beat with tag 1..NUM_STRIPES XORs bw_data into the accumulator half selected by bw_half.
REQ-027 Beats for the same half in consecutive cycles accumulate without loss.
REQ-028 WAIT_STRIPES counts DONE responses with stripe tags; at NUM_STRIPES -> WRITE_PARITY.
REQ-029 WRITE_PARITY issues WRITE_NA to parity + offset with tag 0x80.
REQ-030 br_data returns the accumulator half selected by br_half one cycle after a br_valid with tag 0x80.
REQ-031 WAIT_WRITE on the tag-0x80 response: offset += 128; -> DONE if offset equals size, else -> READ_STRIPES.
REQ-032 Any rsp_code not equal to 0 -> ERROR: cmd_valid is forced low and error is asserted.
REQ-033 cmd_valid is a single-cycle pulse per command, and is never asserted while cmd_credit is low.
REQ-034 Beats and responses whose tags are unexpected in the current state are ignored.
REQ-035 A bw beat and an rsp in the same cycle are both honoured; the beat is applied before the count is evaluated.

Reset
REQ-036 While reset_n is low: state = IDLE; cmd_valid = 0; tag = 0; address = 0; accumulator = 0; offset = 0; done = 0; error = 0; br_data = 0.
REQ-037 Reset asserted mid-job aborts the job immediately, with no further commands after deassertion until the next enabled cycle restarts from IDLE.

Verification
REQ-038 NUM_STRIPES=2, size=128, stripe1 all 0xAA, stripe2 all 0x55 -> one parity write whose br_data is all 0xFF, then done=1.
REQ-039 NUM_STRIPES=4, size=384 -> 3 lines, 12 reads and 3 writes at offsets 0, 128, 256, then done.
REQ-040 size=0 -> only the descriptor read is issued; done=1 and no other commands.
REQ-041 Stripe-2 response code 0x01 -> error=1, no parity write, cmd_valid stays 0.
REQ-042 cmd_credit held low for 5 cycles during READ_STRIPES -> no cmd_valid in that window; reads resume in order.
REQ-043 reset_n pulsed low while in WAIT_STRIPES -> all outputs at reset values in the same cycle; the restarted job re-fetches the descriptor.
